answer_table: RTL and testbench
===============================

# answer_table

Parametrised answer-word table for the telemetry frame generator. Serves one word per read request from a frame of DEPTH words: word 0 is a running frame counter, words 1..DEPTH-2 come from a writable table, and the last word is either a table entry or a running per-frame checksum. Sits between the frame sequencer (which drives the read address) and the serializer (which consumes `data`/`data_vld`). A host-side write port allows retuning table contents and presetting the counter at run time.

## Interface
- DATA_W, 8, width of every word, the counter and the checksum
- ADDR_W, 5, address width for reads and writes
- DEPTH, 20, words per frame (2..2^ADDR_W)
- CHK_EN, 1, 1: the last word returns the checksum; 0: the last word returns its table entry
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request
- addr  in  ADDR_W  read address
- data  out  DATA_W  read data, registered
- data_vld  out  1  one-cycle pulse qualifying `data`
- rd_err  out  1  one-cycle pulse: the last read had addr >= DEPTH
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- frame_cnt  out  DATA_W  current frame counter
- cnt_wrap  out  1  one-cycle pulse when the counter wraps from all-ones to 0

## Operation
- Reset: data=0, data_vld=0, rd_err=0, frame_cnt=0, cnt_wrap=0, checksum acc=0, armed=1. Table entry k (1..DEPTH-1) = (10*k) mod 2^DATA_W.
- Read (rd_en=1, registered next cycle, data_vld=1):
  - addr=0: data=frame_cnt, acc<=frame_cnt, armed<=1.
  - addr 1..DEPTH-2: data=table[addr], acc<=acc+table[addr] (mod 2^DATA_W).
  - addr=DEPTH-1: data=acc if CHK_EN else table[addr]. acc is unchanged. If armed: frame_cnt<=frame_cnt+1, armed<=0.
  - addr>=DEPTH: data=0, rd_err=1, no other state change.
- rd_en=0: data holds its last value, data_vld=0.
- Counter increments at most once per arming. Repeated reads of DEPTH-1 without an intervening addr-0 read do not increment the counter. The counter wraps from 2^DATA_W-1 to 0 and asserts cnt_wrap for one cycle.
- Write (wr_en=1): wr_addr=0 loads frame_cnt<=wr_data and does not change armed. wr_addr 1..DEPTH-1 loads the table entry; a write to DEPTH-1 when CHK_EN=1 is still stored but is not visible to reads. wr_addr>=DEPTH is ignored silently.

## Timing
- Read latency is 1 cycle: request at edge n; data, data_vld and rd_err are valid after edge n+1. Back-to-back reads sustain 1 word/cycle.
- Read and write to the same table address in the same cycle: the read returns the old value. The new value is visible from the next read.
- Read of addr 0 and a write to addr 0 in the same cycle: the read returns the old counter, and frame_cnt takes wr_data.
- Armed increment and a write to addr 0 in the same cycle: the write wins, and armed still clears. cnt_wrap is not asserted by a write.
- Reset has priority over all inputs. Asserting it mid-frame restores all reset values on the next edge, including table contents, and drops any pending data_vld.
- The acc update for a read at edge n is visible to a DEPTH-1 read issued at edge n+1.

## Test plan
All scenarios use default parameters.
- Reset, then read addr 5 -> data=50, data_vld pulse, frame_cnt=0.
- Back-to-back reads of addr 0..19 -> data 0,10,20..180, then checksum 174 (1710 mod 256). frame_cnt=1 afterward, and a following read of addr 0 -> 1.
- Sweep 0..19, then read addr 19 three more times -> frame_cnt stays 1, and each extra read returns 174.
- Same-cycle write of table[7]=0xAA and read of addr 7 -> data=70. Next read of 7 -> 0xAA. The next sweep checksum -> (174-70+170) mod 256 = 18.
- Write addr 0 = 255, then sweep 0..19 -> addr-0 word=255, frame_cnt becomes 0, and cnt_wrap pulses exactly once.
- Read addr 25 -> data=0, rd_err=1, frame_cnt unchanged. Assert rst after addr 10 of a sweep -> all outputs 0, and the next sweep reproduces the reset-frame values.

Source files
------------

// File: rtl/answer_table_if.sv
// Read/write bus of the telemetry answer-word table.
// Master is the sequencer/host side, slave is the table.
interface answer_table_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              data_vld;
  logic              rd_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] frame_cnt;
  logic              cnt_wrap;

  modport master (
    output rd_en, addr, wr_en, wr_addr, wr_data,
    input  data, data_vld, rd_err, frame_cnt, cnt_wrap
  );

  modport slave (
    input  rd_en, addr, wr_en, wr_addr, wr_data,
    output data, data_vld, rd_err, frame_cnt, cnt_wrap
  );
endinterface

// File: rtl/answer_table.sv
// Answer-word table: frame counter, writable table
// entries and a running per-frame checksum word.
module answer_table #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned CHK_EN = 1
) (
  input logic clk,
  input logic rst,
  answer_table_if.slave bus
);
  localparam logic [ADDR_W:0] DEP =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata;
  logic              armed;
  logic              vld_q;
  logic              err_q;
  logic              wrap_q;
  logic              rd_ok;
  logic              rd0;
  logic              rdl;
  logic              rdm;
  logic              wr_tbl;
  logic              wr_cnt;
  logic              bump;

  assign rd_ok  = {1'b0, bus.addr} < DEP;
  assign rd0    = bus.addr == '0;
  assign rdl    = bus.addr == LAST;
  assign rdm    = rd_ok && !rd0 && !rdl;
  assign wr_cnt = bus.wr_en && bus.wr_addr == '0;
  assign wr_tbl = bus.wr_en && bus.wr_addr != '0
               && {1'b0, bus.wr_addr} < DEP;
  assign bump   = bus.rd_en && rdl && armed;

  // Select the word a read at this address returns.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd0:     rdata = cnt;
      rdm:     rdata = tbl[bus.addr];
      rdl:     rdata = (CHK_EN != 0) ? acc
                                     : tbl[bus.addr];
      default: rdata = '0;
    endcase
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= bus.rd_en;
      err_q <= bus.rd_en && !rd_ok;
      if (bus.rd_en) data_q <= rdata;
    end
  end

  // Table storage; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++)
        tbl[k] <= DATA_W'(10 * k);
    end else if (wr_tbl) begin
      tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Checksum accumulator and one-shot arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      armed <= 1'b1;
    end else if (bus.rd_en) begin
      if (rd0) begin
        acc   <= cnt;
        armed <= 1'b1;
      end else if (rdm) begin
        acc <= acc + tbl[bus.addr];
      end else if (bump) begin
        armed <= 1'b0;
      end
    end
  end

  // Frame counter; a host preset beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= bump && !wr_cnt && (cnt == '1);
      if (wr_cnt)    cnt <= bus.wr_data;
      else if (bump) cnt <= cnt + 1'b1;
    end
  end

  assign bus.data      = data_q;
  assign bus.data_vld  = vld_q;
  assign bus.rd_err    = err_q;
  assign bus.frame_cnt = cnt;
  assign bus.cnt_wrap  = wrap_q;
endmodule

// File: tb/tb_answer_table.sv
// Directed bench for answer_table with default
// parameters and hand-computed expected words.
module tb_answer_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;
  int wraps    = 0;
  int et [20];

  answer_table_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  answer_table #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(20), .CHK_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic rd(int a, int exp, int err);
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.addr  = 5'(a);
    @(posedge clk);
    #1;
    if (bus.cnt_wrap) wraps++;
    chk($sformatf("vld@%0d", a), 32'(bus.data_vld), 1);
    chk($sformatf("data@%0d", a), 32'(bus.data),
        32'(exp));
    chk($sformatf("err@%0d", a), 32'(bus.rd_err),
        32'(err));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    if (bus.cnt_wrap) wraps++;
    chk("idle_vld", 32'(bus.data_vld), 0);
  endtask

  task automatic wr(int a, int d);
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = 8'(d);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic sweep(int w0, int cs);
    rd(0, w0, 0);
    for (int i = 1; i < 19; i++) rd(i, et[i], 0);
    rd(19, cs, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 20; k++) et[k] = 10 * k;
    bus.rd_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_vld", 32'(bus.data_vld), 0);
    chk("rst_err", 32'(bus.rd_err), 0);
    chk("rst_cnt", 32'(bus.frame_cnt), 0);
    chk("rst_wrap", 32'(bus.cnt_wrap), 0);
    @(negedge clk);
    rst = 1'b0;

    rd(5, 50, 0);
    chk("cnt_after5", 32'(bus.frame_cnt), 0);
    idle();
    chk("hold_data", 32'(bus.data), 50);

    sweep(0, 174);
    idle();
    chk("cnt_sweep1", 32'(bus.frame_cnt), 1);
    rd(0, 1, 0);
    idle();

    do_reset();
    sweep(0, 174);
    for (int r = 0; r < 3; r++) begin
      rd(19, 174, 0);
      chk("cnt_rep19", 32'(bus.frame_cnt), 1);
    end
    idle();

    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 8'hAA;
    bus.rd_en   = 1'b1;
    bus.addr    = 5'd7;
    @(posedge clk);
    #1;
    chk("rw_same_old", 32'(bus.data), 70);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rd(7, 170, 0);
    et[7] = 170;
    idle();
    wr(0, 0);
    chk("cnt_preset0", 32'(bus.frame_cnt), 0);
    sweep(0, 18);
    idle();
    chk("cnt_sweep_aa", 32'(bus.frame_cnt), 1);

    wr(0, 255);
    chk("cnt_preset255", 32'(bus.frame_cnt), 255);
    chk("wrap_on_write", 32'(bus.cnt_wrap), 0);
    wraps = 0;
    sweep(255, 17);
    idle();
    chk("wrap_count", 32'(wraps), 1);
    chk("cnt_wrapped", 32'(bus.frame_cnt), 0);
    chk("wrap_dropped", 32'(bus.cnt_wrap), 0);

    rd(25, 0, 1);
    chk("cnt_after_err", 32'(bus.frame_cnt), 0);
    idle();
    chk("err_dropped", 32'(bus.rd_err), 0);

    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 8'h40;
    bus.rd_en   = 1'b1;
    bus.addr    = 5'd0;
    @(posedge clk);
    #1;
    chk("rw0_old_cnt", 32'(bus.data), 0);
    chk("rw0_new_cnt", 32'(bus.frame_cnt), 64);
    @(negedge clk);
    bus.wr_en = 1'b0;

    for (int i = 1; i <= 10; i++) rd(i, et[i], 0);
    @(negedge clk);
    rst       = 1'b1;
    bus.rd_en = 1'b1;
    bus.addr  = 5'd11;
    @(posedge clk);
    #1;
    chk("mid_rst_data", 32'(bus.data), 0);
    chk("mid_rst_vld", 32'(bus.data_vld), 0);
    chk("mid_rst_cnt", 32'(bus.frame_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rd_en = 1'b0;
    et[7] = 70;
    sweep(0, 174);
    idle();
    chk("cnt_post_rst", 32'(bus.frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
